load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 20, giving the word-address width of the attached data RAM.
REQ-002 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have req_valid  input  1  CPU access request.
REQ-005 SHALL have req_ready  output  1  unit able to accept a request.
REQ-006 SHALL have req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-008 SHALL have req_signed  input  1  sign-extend a sub-word load.
REQ-009 SHALL have req_addr  input  32  byte address.
REQ-010 SHALL have req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have resp_rdata  output  32  load result, extended.
REQ-013 SHALL have addr_err  output  1  misaligned-access flag, valid with resp_valid.
REQ-014 SHALL have ram_ena, ram_wena  output  1 each  RAM enable and write enable.
REQ-015 SHALL have ram_addr  output  DEPTH  word index, equal to req_addr[DEPTH+1:2].
REQ-016 SHALL have ram_wdata  output  32  full word to write.
REQ-017 SHALL have ram_rdata  input  32  word read combinationally, same cycle as ram_addr.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, DONE and ERR; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL, in IDLE, register the request (addr, size, signed, we, wdata) on req_valid && req_ready.
REQ-020 SHALL route an accepted load to RD -> DONE, giving resp_valid 2 cycles after acceptance.
REQ-021 SHALL route an accepted word store to WR -> DONE, giving resp_valid 2 cycles after acceptance.
REQ-022 SHALL route an accepted byte/half store through read-modify-write RD -> WR -> DONE, giving resp_valid 3 cycles after acceptance.
REQ-023 SHALL, in RD, assert ram_ena=1 and ram_wena=0 and capture ram_rdata into an internal word register.
REQ-024 SHALL, in WR, assert ram_ena=1 and ram_wena=1 for exactly one cycle; ram_wdata is the captured word with only the addressed lanes replaced.
REQ-025 SHALL use little-endian lanes: byte lane = addr[1:0] and half lane = addr[1]; the replacement byte is req_wdata[7:0] and the replacement half is req_wdata[15:0].
REQ-026 SHALL extract a load from the addressed lane and zero-extend it, or sign-extend it when req_signed=1; a word load ignores req_signed.
REQ-027 SHALL hold resp_rdata stable from DONE until the next load completes; stores leave it unchanged.
REQ-028 SHALL keep ram_ena=0 in IDLE, DONE and ERR; DONE and ERR return to IDLE after one cycle.
REQ-029 SHALL accept a new request on the first IDLE cycle after DONE; back-to-back requests never overlap.
REQ-030 SHALL wrap address bits above DEPTH+1 silently and not flag them as an error.

Reset
REQ-031 SHALL, on rst, go to IDLE and set req_ready=1, resp_valid=0, addr_err=0, resp_rdata=0, ram_ena=0, ram_wena=0 and ram_wdata=0.
REQ-032 SHALL, if rst is asserted in RD or WR, abandon the access with no RAM write in that cycle and no resp_valid pulse.
REQ-033 SHALL give rst priority over a simultaneous req_valid.

Configuration
REQ-034 SHALL honour macro LSU_MISALIGN_TRAP_EN. When defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes IDLE -> ERR, pulses resp_valid=1 and addr_err=1, and performs no RAM access. When undefined, misaligned low address bits are cleared before use and addr_err is tied to 0.

Structure
REQ-035 SHALL take size encodings and state encodings from the shared CPU package (lsu_pkg) as named constants.
REQ-036 SHALL place lane extract/extend and lane merge in one combinational sub-module, lsu_lane_mux.

Verification
REQ-037 SHALL cover: word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> resp_rdata=0xDEADBEEF; resp_valid 2 cycles after each acceptance.
REQ-038 SHALL cover: byte store 0x80 at 0x12 over word 0xDEADBEEF -> RAM word 0xDE80BEEF; signed byte load 0x12 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 SHALL cover: half store 0x1234 at 0x16 over 0x00000000 -> word 0x12340000; signed half load 0x16 -> 0x00001234.
REQ-040 SHALL cover: word load at 0x13 with macro defined -> resp_valid=1, addr_err=1, no ram_ena; without macro -> reads word 0x10, addr_err=0.
REQ-041 SHALL cover: rst asserted during WR of a byte store -> memory unchanged, no resp_valid, req_ready=1 on the next cycle.
REQ-042 SHALL cover: req_valid held high continuously -> req_ready pulses only in IDLE, and each request completes exactly once.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access size encodings and FSM state encoding.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane extract/extend for loads and lane merge for stores; purely combinational.
// Zero latency, no flow control.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;

  always_comb begin
    sh        = 5'd0;
    shifted   = word;
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        sh        = {lane, 3'b000};
        shifted   = word >> sh;
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        merged    = (word & ~(32'h0000_00FF << sh)) | ({24'd0, wdata[7:0]} << sh);
      end
      SZ_HALF: begin
        sh        = {lane[1], 4'b0000};
        shifted   = word >> sh;
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        merged    = (word & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata[15:0]} << sh);
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding CPU load/store unit; loads and word stores respond 2 cycles after accept, sub-word stores 3 (RMW).
// req_ready only in IDLE; optional misalignment trap via LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             addr_err,
  output logic             ram_ena,
  output logic             ram_wena,
  output logic [DEPTH-1:0] ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata
);

  lsu_state_t       state, state_nxt;
  logic [DEPTH+1:0] addr_q, addr_n;
  logic [1:0]       size_q, size_n;
  logic             signed_q, we_q, accept;
  logic [31:0]      wdata_q, word_q, rdata_q;
  logic [31:0]      mux_word, load_data, merged;
  logic             unused_hi;

  // Address bits above the RAM window wrap silently.
  assign unused_hi = ^req_addr[31:DEPTH+2];

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    size_n = (req_size == SZ_WORD_ALT) ? SZ_WORD : req_size;
    addr_n = req_addr[DEPTH+1:0];
    if (size_n == SZ_HALF) addr_n[0]   = 1'b0;
    if (size_n == SZ_WORD) addr_n[1:0] = 2'b00;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if ((size_n == SZ_HALF && req_addr[0]) || (size_n == SZ_WORD && req_addr[1:0] != 2'b00))
            state_nxt = ERR;
          else
`endif
          if (!req_we || size_n != SZ_WORD) state_nxt = RD;
          else                              state_nxt = WR;
        end
      end
      RD:      state_nxt = we_q ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= addr_n;
        size_q   <= size_n;
        signed_q <= req_signed;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
      end
      if (state == RD) begin
        word_q <= ram_rdata;
        if (!we_q) rdata_q <= load_data;
      end
    end
  end

  // In RD the lane mux sees the live RAM word; in WR it merges into the captured copy.
  assign mux_word = (state == RD) ? ram_rdata : word_q;

  lsu_lane_mux u_lane_mux (
    .word      (mux_word),
    .lane      (addr_q[1:0]),
    .size      (size_q),
    .sign_ext  (signed_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Reset gates the RAM strobes so an abandoned access never writes.
  assign req_ready  = (state == IDLE);
  assign resp_valid = ((state == DONE) || (state == ERR)) && !rst;
  assign resp_rdata = rdata_q;
  assign ram_ena    = ((state == RD) || (state == WR)) && !rst;
  assign ram_wena   = (state == WR) && !rst;
  assign ram_addr   = addr_q[DEPTH+1:2];
  assign ram_wdata  = ram_wena ? merged : 32'd0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign addr_err = (state == ERR) && !rst;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural memory/response model and a per-cycle compare process.
module tb_load_store_unit;

  localparam int DEPTH = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we, req_signed;
  logic [1:0]       req_size;
  logic [31:0]      req_addr, req_wdata;
  logic             resp_valid, addr_err, ram_ena, ram_wena;
  logic [31:0]      resp_rdata, ram_wdata, ram_rdata;
  logic [DEPTH-1:0] ram_addr;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .addr_err   (addr_err),
    .ram_ena    (ram_ena),
    .ram_wena   (ram_wena),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Attached RAM: combinational read, write on the clock edge.
  logic [31:0] dut_mem [0:255];
  logic        clr_mem;
  assign ram_rdata = dut_mem[ram_addr[7:0]];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) dut_mem[i] <= 32'd0;
    end else if (ram_ena && ram_wena) begin
      dut_mem[ram_addr[7:0]] <= ram_wdata;
    end
  end

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        chk_mem;
    int          idx;
    logic [31:0] mem_word;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [31:0] model_mem [0:255];
  logic [31:0] last_load;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          ram_ena_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (ram_ena) ram_ena_cnt++;
    if (rst) begin
      acc_q.delete();
      check("rst_ram_ena", {31'd0, ram_ena}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    end else begin
      if (ram_ena || req_ready) check("ready_excl_ram", {31'd0, ram_ena & req_ready}, 32'd0);
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=resp_valid=1 required=no response pending (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("latency", 32'(cyc - a), 32'(e.lat));
          check("resp_rdata", resp_rdata, e.rdata);
          check("addr_err", {31'd0, addr_err}, {31'd0, e.err});
          if (e.chk_mem) check("ram_word", dut_mem[e.idx], e.mem_word);
        end
      end
    end
  end

  // Computes the architectural result of one access and queues it, then presents it to the DUT.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    exp_t        e;
    logic [31:0] ea, w, v;
    int          idx, sh;
    bit          got;
    ea = addr;
    if (size == 2'b01) ea = ea & ~32'd1;
    if (size[1])       ea = ea & ~32'd3;
    idx = int'((ea >> 2) & 32'hFF);
    sh  = int'(ea & 32'd3) * 8;
    e.err = 1'b0; e.chk_mem = we; e.idx = idx; e.mem_word = 32'd0;
    e.lat = 2; e.rdata = last_load;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 2'b01 && addr[0]) || (size[1] && (addr & 32'd3) != 0)) begin
      e.err = 1'b1; e.lat = 1; e.chk_mem = 1'b0;
    end else
`endif
    begin
      w = model_mem[idx];
      if (we) begin
        if (size == 2'b00) begin
          w = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh); e.lat = 3;
        end else if (size == 2'b01) begin
          w = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh); e.lat = 3;
        end else begin
          w = wdata;
        end
        model_mem[idx] = w;
        e.mem_word = w;
      end else begin
        v = w >> sh;
        if (size == 2'b00)      v = (sgn && v[7])  ? (v | 32'hFFFF_FF00) : (v & 32'hFF);
        else if (size == 2'b01) v = (sgn && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'hFFFF);
        last_load = v;
        e.rdata   = v;
      end
    end
    exp_q.push_back(e);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready && !rst) got = 1'b1;
    end
    check("accept_timeout", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int ena0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    last_load = 32'd0;
    clr_mem = 1'b1;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0; clr_mem = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_addr_err", {31'd0, addr_err}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_ram_ena", {31'd0, ram_ena}, 32'd0);
    check("reset_ram_wena", {31'd0, ram_wena}, 32'd0);
    check("reset_ram_wdata", ram_wdata, 32'd0);
    check("reset_no_write", dut_mem[4], 32'd0);
    @(posedge clk); #1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0); wait_done();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);        wait_done();
    check("word_load_lit", resp_rdata, 32'hDEADBEEF);

    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h80, 1'b0);       wait_done();
    check("byte_rmw_lit", dut_mem[4], 32'hDE80BEEF);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 1'b0);        wait_done();
    check("sbyte_load_lit", resp_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 1'b0);        wait_done();
    check("ubyte_load_lit", resp_rdata, 32'h00000080);

    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234, 1'b0);     wait_done();
    check("half_rmw_lit", dut_mem[5], 32'h12340000);
    issue(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 1'b0);        wait_done();
    check("shalf_load_lit", resp_rdata, 32'h00001234);

    ena0 = ram_ena_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 1'b0);        wait_done();
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_rdata_kept", resp_rdata, 32'h00001234);
    check("misalign_no_ram", 32'(ram_ena_cnt - ena0), 32'd0);
`else
    check("misalign_word_lit", resp_rdata, 32'hDE80BEEF);
    check("misalign_one_read", 32'(ram_ena_cnt - ena0), 32'd1);
`endif

    issue(1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0); wait_done();
    issue(1'b0, 2'b11, 1'b1, 32'h0040_0040, 32'd0, 1'b0); wait_done();
    check("wrap_word_lit", resp_rdata, 32'hCAFEF00D);
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF8001, 1'b0); wait_done();
    issue(1'b0, 2'b01, 1'b1, 32'h42, 32'd0, 1'b0);        wait_done();
    check("shalf_neg_lit", resp_rdata, 32'hFFFF8001);
    issue(1'b0, 2'b00, 1'b0, 32'h43, 32'd0, 1'b0);        wait_done();
    check("ubyte_hi_lit", resp_rdata, 32'h00000080);

    // Reset lands on the WR cycle of a byte store.
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0); wait_done();
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(negedge clk);
    check("abort_accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_no_wena", {31'd0, ram_wena}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; last_load = 32'd0;
    @(negedge clk);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_mem_kept", dut_mem[8], 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // req_valid held high across three requests.
    issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h55, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h30, 32'd0, 1'b0);
    wait_done();
    check("stream_last_lit", resp_rdata, 32'h00000055);
    check("stream_mem_lit", dut_mem[12], 32'h00000055);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
